// File: rtl/sbc32_pkg.sv
// rtl/sbc32_pkg.sv - shared types and sizing helpers for the serial subtract-with-borrow unit
// Contents: state_t (S_IDLE, S_RUN, S_DONE), CHUNK_DEFAULT, nchunk_of(), kw_of().
package sbc32_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CHUNK_DEFAULT = 8;

  // Number of slices needed to cover the 32-bit operand.
  function automatic int nchunk_of(input int chunk);
    return 32 / chunk;
  endfunction

  // Slice-index width; a single-slice build still needs a 1-bit index.
  function automatic int kw_of(input int chunk);
    return (32 / chunk > 1) ? $clog2(32 / chunk) : 1;
  endfunction

  localparam int NCHUNK_DEFAULT = nchunk_of(CHUNK_DEFAULT);
  localparam int KW_DEFAULT     = kw_of(CHUNK_DEFAULT);

endpackage

// File: rtl/sbc_slice.sv
// rtl/sbc_slice.sv - combinational W-bit subtract-with-borrow slice
// Ports: a, b (W-bit operands), bin (borrow in) -> r (W-bit difference),
//        bout (borrow out of the MSB), msb_bin (borrow into the MSB, for overflow).
module sbc_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] r,
  output logic         bout,
  output logic         msb_bin
);

  // One extra bit on top catches the borrow out of the slice.
  logic [W:0] full;
  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign r    = full[W-1:0];
  assign bout = full[W];

  // Borrow into the MSB comes from subtracting only the bits below it.
  generate
    if (W == 1) begin : g_one
      assign msb_bin = bin;
    end else begin : g_lo
      logic [W-1:0] lo;
      assign lo      = {1'b0, a[W-2:0]} - {1'b0, b[W-2:0]} - {{(W-1){1'b0}}, bin};
      assign msb_bin = lo[W-1];
    end
  endgenerate

endmodule

// File: rtl/sbc32_serial.sv
// rtl/sbc32_serial.sv - multi-cycle 32-bit subtract-with-borrow, one CHUNK-bit slice per clock
// Ports: clk, rst (sync, active high), start, A, B, Bin -> busy, done (1-cycle pulse),
//        D[32:0] = {borrow_out, difference}, zero, neg, ovf.
// Build option: define SBC32_FLAGS_EN to compute zero/neg/ovf; otherwise they are tied to 0.
module sbc32_serial
  import sbc32_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [32:0] D,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);

  localparam int NCHUNK = nchunk_of(CHUNK);
  localparam int KW     = kw_of(CHUNK);

  state_t        state, state_nx;
  logic [31:0]   a_q, b_q;
  logic          borrow_q;
  logic [KW-1:0] k_q;
  logic [32:0]   d_q;

  logic [CHUNK-1:0] a_sl, b_sl, r;
  logic             bout;
  logic             last;
  logic             accept;
  logic [31:0]      d_lo_nx;

  // Slice muxes and the difference word with the current slice merged in.
  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    d_lo_nx = d_q[31:0];
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        a_sl                   = a_q[i*CHUNK +: CHUNK];
        b_sl                   = b_q[i*CHUNK +: CHUNK];
        d_lo_nx[i*CHUNK +: CHUNK] = r;
      end
    end
  end

  assign last   = (k_q == KW'(NCHUNK - 1));
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef SBC32_FLAGS_EN
  logic msb_bin;
`else
  logic unused_msb_bin;
`endif

  sbc_slice #(.W(CHUNK)) u_slice (
    .a       (a_sl),
    .b       (b_sl),
    .bin     (borrow_q),
    .r       (r),
    .bout    (bout),
`ifdef SBC32_FLAGS_EN
    .msb_bin (msb_bin)
`else
    .msb_bin (unused_msb_bin)
`endif
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = start ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      d_q      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q       <= A;
        b_q       <= B;
        borrow_q  <= Bin;
        k_q       <= '0;
        d_q[31:0] <= '0;
      end else if (state == S_RUN) begin
        d_q[31:0] <= d_lo_nx;
        borrow_q  <= bout;
        k_q       <= k_q + KW'(1);
        if (last) d_q[32] <= bout;
      end
    end
  end

  assign D = d_q;

`ifdef SBC32_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  // Flags are taken from the completed word on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if ((state == S_RUN) && last) begin
      zero_q <= (d_lo_nx == 32'd0);
      neg_q  <= d_lo_nx[31];
      ovf_q  <= msb_bin ^ bout;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: doc/sbc32_serial.md
# sbc32_serial

Multi-cycle 32-bit subtract-with-borrow unit, the subtracting counterpart of the team's 33-bit add-with-carry datapath. It computes D = A − B − Bin in CHUNK-bit slices, one slice per clock, with the inter-slice borrow held in a register. Operands and results use the same 33-bit convention as the adder: bit 32 is the carry/borrow-out. It sits beside the ALU as the slow, area-cheap subtract path, driven by a start/done handshake from the lab CPU control FSM.

## Interface
- CHUNK, 8: slice width in bits; legal values 1, 2, 4, 8, 16, 32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  32  minuend.
- B  in  32  subtrahend.
- Bin  in  1  borrow-in.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse; D is valid.
- D  out  33  {borrow_out, difference[31:0]}; held until the next accepted start.
- zero  out  1  D[31:0] == 0.
- neg  out  1  D[31].
- ovf  out  1  two's-complement overflow of A − B − Bin.

## Operation
- NCHUNK = 32/CHUNK.
- States:
  - IDLE → RUN on start.
  - RUN → RUN while k < NCHUNK−1.
  - RUN → DONE after slice NCHUNK−1.
  - DONE → RUN on start; otherwise DONE → IDLE.
- On accept: latch A, B into operand registers; borrow register ← Bin; k ← 0; clear D[31:0].
- Each RUN cycle: {b, r} = A[k] − B[k] − borrow, on CHUNK-bit slice k (LSB first).
  - D slice k ← r; borrow ← b; k ← k+1.
  - The final slice also writes D[32] ← b.
- Arithmetic is width-exact.
  - D[32] = 1 iff unsigned A < B + Bin.
  - D[31:0] = (A − B − Bin) mod 2^32.
- start in RUN is ignored. Operands are not re-sampled. There is no error indication.
- Input operands may change freely after the accept edge.
- Reset has priority over everything, including mid-RUN:
  - Next state IDLE; k = 0; borrow = 0.
  - D = 0; busy = 0; done = 0.
  - zero, neg, ovf = 0.
- Flags are registered and update only in the cycle done is asserted; otherwise they hold their value.

## Timing
- Start sampled at edge 0 → busy high from edge 0 to edge NCHUNK.
- done is high for exactly the one cycle after edge NCHUNK; latency is NCHUNK cycles (4 at CHUNK = 8).
- busy and done are never high together.
- Back-to-back: start during the done cycle is accepted. busy rises at the next edge, so the throughput is one result per NCHUNK+1 cycles.
- D[31:0] shows partial slices during RUN. Consumers must only use D when done is high, or afterwards until the next accept.
- CHUNK = 32: single RUN cycle, latency 1.

## Configuration
- SBC32_FLAGS_EN defined:
  - zero, neg, ovf are computed in the DONE transition.
  - ovf = borrow into bit 31 XOR borrow out of bit 31, captured from the final slice.
- SBC32_FLAGS_EN undefined:
  - zero, neg, ovf are tied to 0 and no flag logic is synthesized.
  - Ports remain, so instantiations are identical.

## Structure
- Package sbc32_pkg holds:
  - the state encoding (IDLE, RUN, DONE);
  - the default CHUNK;
  - the NCHUNK derivation;
  - the slice-index width constant.
- Sub-module sbc_slice: combinational CHUNK-bit subtract-with-borrow.
  - Inputs: a, b, bin. Outputs: r, bout, plus the MSB borrow-in used for ovf.
  - Instantiated once; it is fed by slice muxes indexed by k.

## Test plan
- A=5, B=3, Bin=0, CHUNK=8 → done exactly 4 cycles after the accept edge, D=33'h0_0000_0002, zero=0, neg=0, ovf=0.
- A=0, B=1, Bin=0 → D=33'h1_FFFF_FFFF, neg=1, ovf=0.
- A=32'h0000_0100, B=0, Bin=1 → borrow crosses the slice-0/1 boundary; D=33'h0_0000_00FF.
- A=32'h8000_0000, B=1, Bin=0 → D=33'h0_7FFF_FFFF, ovf=1 with SBC32_FLAGS_EN, ovf=0 without it.
- A=B=32'hDEAD_BEEF, Bin=0, then start with new operands during the done cycle:
  - first result: D=0, zero=1;
  - second result: correct after NCHUNK more cycles.
- Ignored start and mid-RUN reset:
  - start pulsed in RUN cycle 2 with different operands → ignored; the first result is unchanged.
  - rst in RUN cycle 2 → next cycle busy=0, done=0, D=0; no done pulse follows.
